rv32m_div_ctrl: RTL

Front-end controller for the RV32M divide instructions DIV, DIVU, REM and REMU, placed directly upstream of the 32-bit unsigned restoring divider core. It takes operands and the op from the execute stage over a valid/ready handshake and resolves the architectural special cases (divide-by-zero, signed overflow) without using the core. For all other cases it converts signed operands to magnitudes, launches the core with a one-cycle start, waits for busy to fall, and applies sign correction. The result is presented on a valid/ready output handshake.

---
 rtl/rv32m_div_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32m_div_ctrl.sv
// rv32m_div_ctrl: front end for RV32M DIV/DIVU/REM/REMU ahead of an unsigned restoring divider.
// It resolves divide-by-zero and signed overflow locally, otherwise feeds operand magnitudes
// to the core and sign-corrects the quotient or remainder it returns.
// Optional: define DIV_RESULT_CACHE_EN to keep the last core result and reuse it for a
// request with the same operands and signedness (e.g. REM right after DIV).
module rv32m_div_ctrl #(
    parameter int unsigned WATCHDOG_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rstLow,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        err_out,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_start,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_busy
);

    localparam int unsigned WdW = $clog2(WATCHDOG_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StCheck, StWait, StFix, StDone} state_e;

    state_e           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_err;
    logic             r_start;
    logic [31:0]      r_result;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WdW-1:0]   r_wdog;

    // op[0]=0 selects the signed forms, op[1]=1 selects the remainder
    logic        w_signed;
    logic        w_is_rem;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_ovf;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic        w_hit;
    logic [31:0] w_hit_val;

    assign w_signed = ~op[0];
    assign w_is_rem = op[1];
    assign w_abs_a  = (w_signed && rs1[31]) ? (~rs1 + 32'd1) : rs1;
    assign w_abs_b  = (w_signed && rs2[31]) ? (~rs2 + 32'd1) : rs2;
    assign w_ovf    = w_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign w_q_fix  = r_neg_q ? (~div_q + 32'd1) : div_q;
    assign w_r_fix  = r_neg_r ? (~div_r + 32'd1) : div_r;

`ifdef DIV_RESULT_CACHE_EN
    logic        r_c_valid;
    logic        r_c_sgn;
    logic [31:0] r_c_rs1;
    logic [31:0] r_c_rs2;
    logic [31:0] r_c_q;
    logic [31:0] r_c_r;
    logic        r_k_sgn;
    logic [31:0] r_k_rs1;
    logic [31:0] r_k_rs2;

    assign w_hit     = r_c_valid && (r_c_rs1 == rs1) && (r_c_rs2 == rs2) && (r_c_sgn == w_signed);
    assign w_hit_val = w_is_rem ? r_c_r : r_c_q;

    // Track the accepted operands and record both corrected results of each core operation
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            r_c_valid <= 1'b0;
            r_c_sgn   <= 1'b0;
            r_c_rs1   <= '0;
            r_c_rs2   <= '0;
            r_c_q     <= '0;
            r_c_r     <= '0;
            r_k_sgn   <= 1'b0;
            r_k_rs1   <= '0;
            r_k_rs2   <= '0;
        end else begin
            if (r_state == StIdle && in_valid) begin
                r_k_sgn <= w_signed;
                r_k_rs1 <= rs1;
                r_k_rs2 <= rs2;
            end
            if (r_state == StFix) begin
                r_c_valid <= 1'b1;
                r_c_sgn   <= r_k_sgn;
                r_c_rs1   <= r_k_rs1;
                r_c_rs2   <= r_k_rs2;
                r_c_q     <= w_q_fix;
                r_c_r     <= w_r_fix;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_val = '0;
`endif

    // Control FSM; every output is registered here
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_start     <= 1'b0;
            r_result    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_is_rem    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_wdog      <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_is_rem   <= w_is_rem;
                        r_neg_q    <= w_signed && (rs1[31] ^ rs2[31]);
                        r_neg_r    <= w_signed && rs1[31];
                        r_a        <= w_abs_a;
                        r_b        <= w_abs_b;
                        if (rs2 == 32'd0) begin
                            r_result    <= w_is_rem ? rs1 : 32'hFFFF_FFFF;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end else if (w_ovf) begin
                            r_result    <= w_is_rem ? 32'd0 : 32'h8000_0000;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end else if (w_hit) begin
                            r_result    <= w_hit_val;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    r_start <= 1'b0;
                    r_state <= StCheck;
                end
                // busy still low here means the core finished at once (dividend < divisor)
                StCheck: begin
                    r_state <= div_busy ? StWait : StFix;
                end
                StWait: begin
                    r_wdog <= r_wdog + WdW'(1);
                    if (!div_busy) begin
                        r_state <= StFix;
                    end else if (r_wdog == WdW'(WATCHDOG_CYCLES - 1)) begin
                        r_result    <= 32'hFFFF_FFFF;
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StFix: begin
                    r_result    <= r_is_rem ? w_r_fix : w_q_fix;
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_wdog      <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign err_out   = r_err;
    assign div_start = r_start;
    assign result    = r_result;
    assign div_a     = r_a;
    assign div_b     = r_b;

endmodule
